fib_lpm: RTL and testbench
==========================

# fib_lpm

Parametrised longest-prefix-match Forwarding Information Base for the NDN router: stores (prefix, length) → outgoing face entries and answers lookups by probing from the requested length down to length 0. It sits between the PIT (lookup requests for outgoing interests) and the control path (insert/delete/clear of routes). Compared with the fixed 64-bit/1024-bucket FIB, it adds per-entry face storage, delete and clear operations, a valid/ready handshake on both sides, and a self-clearing init sweep.

## Interface
- PREFIX_W, 64, prefix width in bits; must equal 2^LEN_W
- LEN_W, 6, length field width; legal lengths 0..PREFIX_W-1
- HASH_W, 8, bucket index width; 2^HASH_W buckets per length
- FACE_W, 4, outgoing face id width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  0 lookup, 1 insert, 2 delete, 3 clear
- cmd_prefix  in  PREFIX_W  left-aligned prefix (bit PREFIX_W-1 = first bit)
- cmd_len  in  LEN_W  prefix length in bits
- cmd_face  in  FACE_W  face to store (insert only)
- rsp_valid  out  1  response present, held until taken
- rsp_ready  in  1  consumer takes response
- rsp_op  out  2  echo of accepted cmd_op
- rsp_hit  out  1  lookup: match found; insert: key already existed; delete: key was present; clear: 0
- rsp_len  out  LEN_W  matched length (lookup hit), else 0
- rsp_face  out  FACE_W  face of match (lookup hit), else 0

## Operation
- Key masking: bits below position PREFIX_W-len are zeroed; len 0 → all-zero key (default route).
- Hash: XOR of the PREFIX_W/HASH_W HASH_W-bit chunks of the masked key; one registered cycle.
- Storage: valid_tbl[2^LEN_W] rows of 2^HASH_W bits; face_tbl[2^(LEN_W+HASH_W)] indexed {len, hash}, no reset. Collisions alias (no tag); accepted by design.
- States: INIT, IDLE, HASH, PROBE, WRITE, CLEAR, RESP.
- INIT: after reset, clears one valid_tbl row per cycle, row counter 0..2^LEN_W-1, then IDLE.
- IDLE: cmd_ready=1; on cmd_valid latch op/prefix/len/face; clear → CLEAR, else → HASH.
- HASH: hash unit computes bucket for current len → PROBE (lookup) or WRITE (insert/delete).
- PROBE: valid → rsp_hit=1, rsp_len=len, rsp_face=face_tbl → RESP; else len==0 → miss → RESP; else len-1 → HASH.
- WRITE: rsp_hit = old valid bit; insert sets valid and writes face (overwrite allowed); delete clears valid → RESP.
- CLEAR: same row sweep as INIT → RESP.
- RESP: rsp_valid=1, outputs stable; on rsp_ready → IDLE.
- Reset value of every output: 0 (cmd_ready 0 during INIT).

## Timing
- Command accepted in cycle T (cmd_valid & cmd_ready).
- Lookup probing k lengths: rsp_valid first high at T+1+2k; hit at requested length → T+3; full miss from len L → T+3+2L.
- Insert/delete: rsp_valid at T+3.
- Clear and INIT: 2^LEN_W cycles of sweep; clear rsp_valid at T+1+2^LEN_W.
- cmd_ready=0 in every state except IDLE; at most one command in flight.
- rsp_ready held low: block stalls in RESP, no command accepted.
- rst asserted mid-operation: immediate return to INIT, rsp_valid dropped, in-flight command lost, table re-cleared.

## Structure
- Package fib_pkg: op codes (OP_LOOKUP/INSERT/DELETE/CLEAR), state enum, default parameter values.
- Sub-module fib_hash: parametrised masking + XOR-fold with one output register; instantiated once.

## Test plan
- Reset, wait: cmd_ready low 64 cycles, then high; lookup 0xFFFF_0000_0000_0000 len 16 → rsp_hit=0, rsp_len=0 at T+35.
- Insert 0xAB00_0000_0000_0000 len 8 face 3 → rsp_hit=0 at T+3; lookup 0xABCD_0000_0000_0000 len 16 → hit, len 8, face 3 at T+19.
- Insert len 0 face 7; lookup 0x1200_0000_0000_0000 len 4 → hit, len 0, face 7 at T+11; re-insert len 0 face 5 → rsp_hit=1, later lookup face 5.
- Delete 0xAB00… len 8 → rsp_hit=1; delete again → rsp_hit=0; lookup 0xABCD… len 16 → falls to default route.
- Clear → rsp at T+65; any lookup then misses; hold rsp_ready low 10 cycles → rsp stable, cmd_ready 0.
- Assert rst during a 9-length probe → all outputs 0 next edge, INIT sweep, previously inserted routes gone.

Source files
------------

// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : fib_pkg
//  Purpose   : Shared op codes, FSM states and default sizes for fib_lpm.
//  Revision  : 1.0
// ============================================================================
package fib_pkg;

    localparam int DEF_PREFIX_W = 64;
    localparam int DEF_LEN_W    = 6;
    localparam int DEF_HASH_W   = 8;
    localparam int DEF_FACE_W   = 4;

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HASH  = 3'd2,
        ST_PROBE = 3'd3,
        ST_WRITE = 3'd4,
        ST_CLEAR = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_hash.sv
`default_nettype none
// ============================================================================
//  Module    : fib_hash
//  Purpose   : Masks a prefix to its length and XOR-folds it into a bucket
//              index; result is registered.
//  Revision  : 1.0
// ============================================================================
module fib_hash
    import fib_pkg::*;
#(
    parameter int PREFIX_W = DEF_PREFIX_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int HASH_W   = DEF_HASH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PREFIX_W-1:0] prefix_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic [HASH_W-1:0]   hash_o
);

    logic [PREFIX_W-1:0] key_w;
    logic [HASH_W-1:0]   hash_d;
    logic [HASH_W-1:0]   hash_q;

    // Prefix is left-aligned: only the top len bits survive.
    always_comb begin
        key_w = prefix_i;
        for (int i = 0; i < PREFIX_W; i++) begin
            if (i + int'(len_i) < PREFIX_W) begin
                key_w[i] = 1'b0;
            end
        end
    end

    always_comb begin
        hash_d = '0;
        for (int c = 0; c < PREFIX_W / HASH_W; c++) begin
            hash_d = hash_d ^ key_w[c*HASH_W +: HASH_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash_q <= '0;
        end else begin
            hash_q <= hash_d;
        end
    end

    assign hash_o = hash_q;

endmodule : fib_hash
`default_nettype wire

// File: rtl/fib_lpm.sv
`default_nettype none
// ============================================================================
//  Module    : fib_lpm
//  Purpose   : Longest-prefix-match FIB with per-entry face storage,
//              insert/delete/clear and valid/ready command/response ports.
//  Revision  : 1.0
// ============================================================================
module fib_lpm
    import fib_pkg::*;
#(
    parameter int PREFIX_W = DEF_PREFIX_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int HASH_W   = DEF_HASH_W,
    parameter int FACE_W   = DEF_FACE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [PREFIX_W-1:0] cmd_prefix,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [FACE_W-1:0]   cmd_face,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_op,
    output logic                rsp_hit,
    output logic [LEN_W-1:0]    rsp_len,
    output logic [FACE_W-1:0]   rsp_face
);

    localparam int NROW  = 2 ** LEN_W;
    localparam int NBKT  = 2 ** HASH_W;
    localparam int NFACE = 2 ** (LEN_W + HASH_W);
    localparam logic [LEN_W-1:0] ROW_LAST = {LEN_W{1'b1}};

    state_t                state_q;
    logic [1:0]            op_q;
    logic [PREFIX_W-1:0]   prefix_q;
    logic [LEN_W-1:0]      len_q;
    logic [FACE_W-1:0]     cface_q;
    logic [LEN_W-1:0]      row_q;
    logic                  cmd_ready_q;
    logic                  rsp_valid_q;
    logic [1:0]            rsp_op_q;
    logic                  rsp_hit_q;
    logic [LEN_W-1:0]      rsp_len_q;
    logic [FACE_W-1:0]     rsp_face_q;

    logic [HASH_W-1:0]     bkt;
    logic                  slot_valid;
    logic [FACE_W-1:0]     slot_face;

    // Tables are cleared by the INIT/CLEAR sweep rather than by reset.
    logic [NBKT-1:0]       valid_tbl [NROW];
    logic [FACE_W-1:0]     face_tbl  [NFACE];

    fib_hash #(
        .PREFIX_W (PREFIX_W),
        .LEN_W    (LEN_W),
        .HASH_W   (HASH_W)
    ) u_hash (
        .clk      (clk),
        .rst      (rst),
        .prefix_i (prefix_q),
        .len_i    (len_q),
        .hash_o   (bkt)
    );

    assign slot_valid = valid_tbl[len_q][bkt];
    assign slot_face  = face_tbl[{len_q, bkt}];

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT || state_q == ST_CLEAR) begin
            valid_tbl[row_q] <= '0;
        end else if (state_q == ST_WRITE) begin
            if (op_q == OP_INSERT) begin
                valid_tbl[len_q][bkt]  <= 1'b1;
                face_tbl[{len_q, bkt}] <= cface_q;
            end else begin
                valid_tbl[len_q][bkt]  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            op_q        <= '0;
            prefix_q    <= '0;
            len_q       <= '0;
            cface_q     <= '0;
            row_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_len_q   <= '0;
            rsp_face_q  <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    row_q <= row_q + LEN_W'(1);
                    if (row_q == ROW_LAST) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        prefix_q    <= cmd_prefix;
                        len_q       <= cmd_len;
                        cface_q     <= cmd_face;
                        row_q       <= '0;
                        state_q     <= (cmd_op == OP_CLEAR) ? ST_CLEAR : ST_HASH;
                    end
                end
                ST_HASH: begin
                    state_q <= (op_q == OP_LOOKUP) ? ST_PROBE : ST_WRITE;
                end
                ST_PROBE: begin
                    if (slot_valid) begin
                        rsp_hit_q   <= 1'b1;
                        rsp_len_q   <= len_q;
                        rsp_face_q  <= slot_face;
                        rsp_op_q    <= op_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (len_q == '0) begin
                        rsp_hit_q   <= 1'b0;
                        rsp_len_q   <= '0;
                        rsp_face_q  <= '0;
                        rsp_op_q    <= op_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        len_q   <= len_q - LEN_W'(1);
                        state_q <= ST_HASH;
                    end
                end
                ST_WRITE: begin
                    rsp_hit_q   <= slot_valid;
                    rsp_len_q   <= '0;
                    rsp_face_q  <= '0;
                    rsp_op_q    <= op_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_CLEAR: begin
                    row_q <= row_q + LEN_W'(1);
                    if (row_q == ROW_LAST) begin
                        rsp_hit_q   <= 1'b0;
                        rsp_len_q   <= '0;
                        rsp_face_q  <= '0;
                        rsp_op_q    <= op_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    row_q   <= '0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_len   = rsp_len_q;
    assign rsp_face  = rsp_face_q;

endmodule : fib_lpm
`default_nettype wire

// File: tb/tb_fib_lpm.sv
`default_nettype none
// ============================================================================
//  Module    : tb_fib_lpm
//  Purpose   : Directed vector table, stall/reset sequences and random
//              traffic against a route-map model of the FIB.
//  Revision  : 1.0
// ============================================================================
module tb_fib_lpm;
    import fib_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_prefix;
    logic [5:0]  cmd_len;
    logic [3:0]  cmd_face;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic        rsp_hit;
    logic [5:0]  rsp_len;
    logic [3:0]  rsp_face;

    always #5 clk = ~clk;

    fib_lpm dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_prefix (cmd_prefix),
        .cmd_len    (cmd_len),
        .cmd_face   (cmd_face),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_op     (rsp_op),
        .rsp_hit    (rsp_hit),
        .rsp_len    (rsp_len),
        .rsp_face   (rsp_face)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Route model: key = len*256 + bucket, value = face.
    int routes [int];

    function automatic logic [7:0] ref_hash(input logic [63:0] p, input int len);
        logic [63:0] m;
        logic [7:0]  h;
        m = (len == 0) ? 64'h0 : (p & ~((64'h1 << (64 - len)) - 64'h1));
        h = 8'h0;
        for (int c = 0; c < 8; c++) h = h ^ 8'(m >> (8 * c));
        return h;
    endfunction

    function automatic int rkey(input logic [63:0] p, input int len);
        return len * 256 + int'(ref_hash(p, len));
    endfunction

    task automatic model(input logic [1:0] op, input logic [63:0] p, input int len,
                         input logic [3:0] f, output logic hit, output logic [5:0] rl,
                         output logic [3:0] rf, output int lat);
        int k;
        hit = 1'b0; rl = 6'd0; rf = 4'd0;
        case (op)
            OP_LOOKUP: begin
                lat = 1 + 2 * (len + 1);
                for (int l = len; l >= 0; l--) begin
                    k = rkey(p, l);
                    if (routes.exists(k)) begin
                        hit = 1'b1; rl = 6'(l); rf = 4'(routes[k]);
                        lat = 1 + 2 * (len - l + 1);
                        break;
                    end
                end
            end
            OP_INSERT: begin
                k = rkey(p, len); hit = routes.exists(k); routes[k] = int'(f); lat = 3;
            end
            OP_DELETE: begin
                k = rkey(p, len); hit = routes.exists(k);
                if (hit) routes.delete(k);
                lat = 3;
            end
            default: begin
                routes.delete(); lat = 65;
            end
        endcase
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic issue(input logic [1:0] op, input logic [63:0] p, input logic [5:0] len,
                         input logic [3:0] f, output logic hit, output logic [5:0] rl,
                         output logic [3:0] rf, output logic [1:0] rop, output int lat);
        int w = 0;
        hit = 1'b0; rl = '0; rf = '0; rop = '0; lat = -1;
        while (!cmd_ready && w < 300) begin @(negedge clk); w++; end
        if (!cmd_ready) begin
            n_vec++; n_bad++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
            return;
        end
        cmd_op = op; cmd_prefix = p; cmd_len = len; cmd_face = f; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin
            n_vec++; n_bad++;
            $display("FAIL rsp_valid_timeout: got 0 expected 1");
            lat = -1;
            return;
        end
        hit = rsp_hit; rl = rsp_len; rf = rsp_face; rop = rsp_op;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] p;
        logic [5:0]  len;
        logic [3:0]  f;
        logic        hit;
        logic [5:0]  elen;
        logic [3:0]  eface;
        int          lat;
    } vec_t;

    vec_t vt [15];

    task automatic wait_init(input string name);
        int cnt = 0;
        while (!cmd_ready && cnt < 200) begin cnt++; @(negedge clk); #1; end
        chk(name, 64'(cnt), 64'd64);
    endtask

    initial begin
        logic        hit, mhit;
        logic [5:0]  rl, mrl;
        logic [3:0]  rf, mrf;
        logic [1:0]  rop;
        int          lat, mlat, sel, len;
        logic [1:0]  op;
        logic [63:0] p;
        logic [63:0] bases [4];

        vt[0]  = '{OP_LOOKUP, 64'hFFFF_0000_0000_0000, 6'd16, 4'd0, 1'b0, 6'd0,  4'd0, 35};
        vt[1]  = '{OP_INSERT, 64'hAB00_0000_0000_0000, 6'd8,  4'd3, 1'b0, 6'd0,  4'd0, 3};
        vt[2]  = '{OP_LOOKUP, 64'hABCD_0000_0000_0000, 6'd16, 4'd0, 1'b1, 6'd8,  4'd3, 19};
        vt[3]  = '{OP_INSERT, 64'h0,                   6'd0,  4'd7, 1'b0, 6'd0,  4'd0, 3};
        vt[4]  = '{OP_LOOKUP, 64'h1200_0000_0000_0000, 6'd4,  4'd0, 1'b1, 6'd0,  4'd7, 11};
        vt[5]  = '{OP_INSERT, 64'h0,                   6'd0,  4'd5, 1'b1, 6'd0,  4'd0, 3};
        vt[6]  = '{OP_LOOKUP, 64'h1200_0000_0000_0000, 6'd4,  4'd0, 1'b1, 6'd0,  4'd5, 11};
        vt[7]  = '{OP_DELETE, 64'hAB00_0000_0000_0000, 6'd8,  4'd0, 1'b1, 6'd0,  4'd0, 3};
        vt[8]  = '{OP_DELETE, 64'hAB00_0000_0000_0000, 6'd8,  4'd0, 1'b0, 6'd0,  4'd0, 3};
        vt[9]  = '{OP_LOOKUP, 64'hABCD_0000_0000_0000, 6'd16, 4'd0, 1'b1, 6'd0,  4'd5, 35};
        vt[10] = '{OP_CLEAR,  64'h0,                   6'd0,  4'd0, 1'b0, 6'd0,  4'd0, 65};
        vt[11] = '{OP_LOOKUP, 64'h1200_0000_0000_0000, 6'd4,  4'd0, 1'b0, 6'd0,  4'd0, 11};
        vt[12] = '{OP_INSERT, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 4'd9, 1'b0, 6'd0,  4'd0, 3};
        vt[13] = '{OP_LOOKUP, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 4'd0, 1'b1, 6'd63, 4'd9, 3};
        vt[14] = '{OP_LOOKUP, 64'hFFFF_FFFF_FFFF_FFFE, 6'd63, 4'd0, 1'b1, 6'd63, 4'd9, 3};

        bases[0] = 64'hAB00_0000_0000_0000;
        bases[1] = 64'h1200_0000_0000_0000;
        bases[2] = 64'hFFFF_0000_0000_0000;
        bases[3] = 64'h0;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_prefix = '0; cmd_len = '0;
        cmd_face = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {cmd_ready, rsp_valid, rsp_op, rsp_hit, rsp_len, rsp_face}, 64'h0);
        rst = 1'b0;
        #1;
        wait_init("init_cycles");

        for (int i = 0; i < 15; i++) begin
            model(vt[i].op, vt[i].p, int'(vt[i].len), vt[i].f, mhit, mrl, mrf, mlat);
            issue(vt[i].op, vt[i].p, vt[i].len, vt[i].f, hit, rl, rf, rop, lat);
            chk($sformatf("vec%0d_op", i),   rop, vt[i].op);
            chk($sformatf("vec%0d_hit", i),  hit, vt[i].hit);
            chk($sformatf("vec%0d_len", i),  rl,  vt[i].elen);
            chk($sformatf("vec%0d_face", i), rf,  vt[i].eface);
            chk($sformatf("vec%0d_lat", i),  64'(lat), 64'(vt[i].lat));
        end

        // Response held while the consumer is not ready; new commands refused.
        rsp_ready = 1'b0;
        cmd_op = OP_LOOKUP; cmd_prefix = 64'hFFFF_FFFF_FFFF_FFFF; cmd_len = 6'd63;
        cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_op = OP_INSERT;
        begin
            int w = 0;
            while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
        end
        for (int i = 0; i < 10; i++) begin
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_rsp_hit",   rsp_hit,   1'b1);
            chk("stall_rsp_face",  rsp_face,  4'd9);
            chk("stall_cmd_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", {rsp_valid, cmd_ready}, 2'b01);

        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 99);
            op  = (sel < 40) ? OP_LOOKUP : (sel < 75) ? OP_INSERT : (sel < 97) ? OP_DELETE : OP_CLEAR;
            p   = {bases[$urandom_range(0, 3)][63:32], 32'($urandom())};
            len = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 20);
            model(op, p, len, 4'($urandom_range(0, 15)), mhit, mrl, mrf, mlat);
            issue(op, p, 6'(len), cmd_face_last(op, p, len), hit, rl, rf, rop, lat);
            chk($sformatf("rnd%0d_resp", n), {rop, hit, rl, rf}, {op, mhit, mrl, mrf});
            chk($sformatf("rnd%0d_lat", n),  64'(lat), 64'(mlat));
        end

        // Reset in the middle of a nine-length probe.
        model(OP_INSERT, 64'hAB00_0000_0000_0000, 8, 4'd3, mhit, mrl, mrf, mlat);
        issue(OP_INSERT, 64'hAB00_0000_0000_0000, 6'd8, 4'd3, hit, rl, rf, rop, lat);
        cmd_op = OP_LOOKUP; cmd_prefix = 64'hABCD_0000_0000_0000; cmd_len = 6'd16;
        cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {cmd_ready, rsp_valid, rsp_op, rsp_hit, rsp_len, rsp_face}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        routes.delete();
        #1;
        wait_init("midrst_init_cycles");
        issue(OP_LOOKUP, 64'hABCD_0000_0000_0000, 6'd16, 4'd0, hit, rl, rf, rop, lat);
        chk("midrst_lookup", {rop, hit, rl, rf}, {OP_LOOKUP, 1'b0, 6'd0, 4'd0});
        chk("midrst_lat", 64'(lat), 64'd35);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Face argument for the random phase: re-reads what the model stored so the
    // DUT receives the same face the model recorded for this insert.
    function automatic logic [3:0] cmd_face_last(input logic [1:0] op, input logic [63:0] p,
                                                 input int len);
        int k;
        k = rkey(p, len);
        if (op == OP_INSERT && routes.exists(k)) return 4'(routes[k]);
        return 4'd0;
    endfunction

endmodule : tb_fib_lpm
`default_nettype wire
